shift_left_op_pipe: RTL and testbench
=====================================

Name: shift_left_op_pipe

Overview:
- Registered logical left shifter: out = a << b, with zero fill and a width of N bits.
- Adds a valid strobe, an overflow flag (set when non-zero bits are shifted out) and a zero-result flag.
- Used as a single-cycle datapath operator inside the CDC synchronizer datapath.
- Combinational core is a log2(N)-stage barrel shifter; all outputs are registered.

Parameters:
- N, 8, data width of a, b and out in bits; legal range 1..64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  qualifies a and b for this cycle.
- a  input  N  operand to be shifted, unsigned.
- b  input  N  shift amount, unsigned; the full N-bit value is significant.
- out  output  N  registered shift result.
- out_valid  output  1  high for one cycle per accepted input.
- ovf  output  1  registered: at least one '1' bit of a was shifted beyond bit N-1.
- zero  output  1  registered: out == 0.

Behaviour:
- Reset:
  - When rst is high at a rising edge: out=0, out_valid=0, ovf=0, zero=1.
  - rst has priority over in_valid in the same cycle; that input is dropped.
- Latency: exactly 1 cycle.
  - An input sampled with in_valid=1 at edge k appears on out/ovf/zero with out_valid=1 after edge k.
  - Full throughput: one result per cycle, no backpressure.
- in_valid=0 at an edge:
  - out_valid goes to 0.
  - out, ovf and zero hold their previous values.
- Arithmetic:
  - Result = (a << b) truncated to N bits, zero-filled from the LSB.
  - b = 0: out = a, ovf = 0.
  - b >= N: out = 0, with ovf = (a != 0). Example: N=8, b=68 gives out=0.
  - The upper bits of b, beyond clog2(N), force the saturated-zero case; they must never alias (no modulo-N wrap).
  - ovf = OR of bits a[N-1 : N-b] for 0 < b < N.
  - zero = (next out == 0).
- N=1: shift of 0 passes a through; any non-zero b gives 0.
- No X propagation from undriven inputs is required.
- a and b are assumed stable around the edge.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, a=8'hFF, b=1 -> out=0, out_valid=0, ovf=0, zero=1 throughout.
- Basic shift: a=8'b00000001, b=2, in_valid=1 -> next cycle out=8'b00000100, ovf=0, zero=0, out_valid=1.
- Mid shift: a=8'b00000011, b=4 -> out=8'b00110000, ovf=0. Then a=8'b11000011, b=4 -> out=8'b00110000, ovf=1.
- Oversized amount: a=8'b00000011, b=8'b01000100 (68) -> out=0, ovf=1, zero=1. Also a=0, b=200 -> out=0, ovf=0, zero=1.
- Boundaries:
  - b=0, a=8'hA5 -> out=8'hA5, ovf=0.
  - b=7, a=8'h01 -> out=8'h80, ovf=0.
  - b=8, a=8'h80 -> out=0, ovf=1.
- Streaming/hold and mid-stream reset:
  - Back-to-back in_valid for 4 cycles with b=0..3, a=1 -> out=1,2,4,8 on consecutive cycles.
  - Then in_valid=0 -> out_valid=0 and out holds 8.
  - Assert rst mid-stream -> out=0 on the next edge.

Source files
------------

// File: rtl/shift_left_op_pipe.sv
// rtl/shift_left_op_pipe.sv - registered N-bit logical left shifter with valid, overflow and zero flags
// Barrel shifter of clog2(N) stages; each stage also reports the one bits it pushes off the top.
module shift_left_op_pipe #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] out,
  output logic         out_valid,
  output logic         ovf,
  output logic         zero
);

  localparam int SW = $clog2(N);

  logic [N-1:0] stage_d [0:SW];
  logic         stage_o [0:SW];
  logic         hi_nz;
  logic [N-1:0] nxt_out;
  logic         nxt_ovf;

  assign stage_d[0] = a;
  assign stage_o[0] = 1'b0;

  for (genvar s = 0; s < SW; s++) begin : g_stage
    localparam int SH = 1 << s;
    assign stage_d[s+1] = b[s] ? (stage_d[s] << SH) : stage_d[s];
    assign stage_o[s+1] = stage_o[s] | (b[s] & (|stage_d[s][N-1 -: SH]));
  end

  // Any b bit above the stage controls means b >= N; saturate instead of wrapping modulo N.
  assign hi_nz   = |b[N-1:SW];
  assign nxt_out = hi_nz ? '0 : stage_d[SW];
  assign nxt_ovf = hi_nz ? (|a) : stage_o[SW];

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b1;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out  <= nxt_out;
        ovf  <= nxt_ovf;
        zero <= (nxt_out == '0);
      end
    end
  end

endmodule

// File: tb/tb_shift_left_op_pipe.sv
// tb/tb_shift_left_op_pipe.sv - vector table plus randomized check of shift_left_op_pipe against an arithmetic model
module tb_shift_left_op_pipe;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [N-1:0] out;
  logic         out_valid;
  logic         ovf;
  logic         zero;

  int checks = 0;
  int failures = 0;

  shift_left_op_pipe #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .out(out), .out_valid(out_valid), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         vld;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] e_out;
    logic         e_valid;
    logic         e_ovf;
    logic         e_zero;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [N-1:0] aa, input logic [N-1:0] bb);
    rst = r; in_valid = v; a = aa; b = bb;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [N-1:0] eo, input logic ev,
                           input logic eov, input logic ez);
    check({tag, ".out"}, 64'(out), 64'(eo));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
    check({tag, ".ovf"}, 64'(ovf), 64'(eov));
    check({tag, ".zero"}, 64'(zero), 64'(ez));
  endtask

  // Reference: shift in a wide integer, then split kept and lost bits.
  logic [N-1:0] m_out;
  logic         m_valid, m_ovf, m_zero;

  task automatic model(input logic r, input logic v, input logic [N-1:0] aa, input logic [N-1:0] bb);
    longint unsigned full;
    if (r) begin
      m_out = '0; m_valid = 1'b0; m_ovf = 1'b0; m_zero = 1'b1;
    end else begin
      m_valid = v;
      if (v) begin
        if (int'(bb) >= N) begin
          m_out = '0;
          m_ovf = (aa != 0);
        end else begin
          full  = longint'(aa) << bb;
          m_out = full[N-1:0];
          m_ovf = (full >> N) != 0;
        end
        m_zero = (m_out == 0);
      end
    end
  endtask

  initial begin
    vecs.push_back('{1, 1, 8'hFF, 8'd1,   8'h00, 0, 0, 1});
    vecs.push_back('{1, 1, 8'hFF, 8'd1,   8'h00, 0, 0, 1});
    vecs.push_back('{0, 1, 8'h01, 8'd2,   8'h04, 1, 0, 0});
    vecs.push_back('{0, 1, 8'h03, 8'd4,   8'h30, 1, 0, 0});
    vecs.push_back('{0, 1, 8'hC3, 8'd4,   8'h30, 1, 1, 0});
    vecs.push_back('{0, 1, 8'h03, 8'd68,  8'h00, 1, 1, 1});
    vecs.push_back('{0, 1, 8'h00, 8'd200, 8'h00, 1, 0, 1});
    vecs.push_back('{0, 1, 8'hA5, 8'd0,   8'hA5, 1, 0, 0});
    vecs.push_back('{0, 1, 8'h01, 8'd7,   8'h80, 1, 0, 0});
    vecs.push_back('{0, 1, 8'h80, 8'd8,   8'h00, 1, 1, 1});
    vecs.push_back('{0, 1, 8'h80, 8'd1,   8'h00, 1, 1, 1});
    vecs.push_back('{0, 1, 8'h01, 8'd16,  8'h00, 1, 1, 1});
    vecs.push_back('{0, 1, 8'h01, 8'd0,   8'h01, 1, 0, 0});
    vecs.push_back('{0, 1, 8'h01, 8'd1,   8'h02, 1, 0, 0});
    vecs.push_back('{0, 1, 8'h01, 8'd2,   8'h04, 1, 0, 0});
    vecs.push_back('{0, 1, 8'h01, 8'd3,   8'h08, 1, 0, 0});
    vecs.push_back('{0, 0, 8'hFF, 8'd1,   8'h08, 0, 0, 0});
    vecs.push_back('{0, 0, 8'h00, 8'd0,   8'h08, 0, 0, 0});
    vecs.push_back('{0, 1, 8'h01, 8'd1,   8'h02, 1, 0, 0});
    vecs.push_back('{1, 1, 8'h01, 8'd1,   8'h00, 0, 0, 1});

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].vld, vecs[i].a, vecs[i].b);
      check_all($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_valid,
                vecs[i].e_ovf, vecs[i].e_zero);
    end

    // After reset, idle cycles must keep the reset flags; then a result with ovf set must hold through idle.
    step(0, 0, 8'hFF, 8'd3);
    check_all("idle_after_rst", 8'h00, 0, 0, 1);
    step(0, 1, 8'hF1, 8'd3);
    check_all("ovf_set", 8'h88, 1, 1, 0);
    step(0, 0, 8'h00, 8'd0);
    check_all("ovf_hold", 8'h88, 0, 1, 0);

    model(1, 0, '0, '0);
    step(1, 0, '0, '0);
    for (int i = 0; i < 400; i++) begin
      logic r, v;
      logic [N-1:0] aa, bb;
      r  = ($urandom_range(0, 31) == 0);
      v  = ($urandom_range(0, 3) != 0);
      aa = N'($urandom);
      case ($urandom_range(0, 3))
        0:       bb = N'($urandom);
        1:       bb = N'($urandom_range(N, 2 * N));
        default: bb = N'($urandom_range(0, N - 1));
      endcase
      if ($urandom_range(0, 7) == 0) aa = '0;
      model(r, v, aa, bb);
      step(r, v, aa, bb);
      check_all($sformatf("rnd%0d", i), m_out, m_valid, m_ovf, m_zero);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
